// File: rtl/ldpc_layer_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ldpc_pkg : one-hot state encoding, null-shift constant and width helpers
//            shared by the layered-LDPC row sequencer.   Rev 1.0
// ----------------------------------------------------------------------------
package ldpc_pkg;

  localparam int DEF_MAX_BLOCK_SIZE = 8;
  localparam int DEF_MAX_LAYERS     = 4;
  localparam int DEF_MAX_ITER       = 15;

  // Width helpers never return 0 so degenerate sizes still give a legal vector.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int width_block(input int max_block_size);
    return clog2_min1(max_block_size);
  endfunction

  function automatic int width_layer(input int max_layers);
    return clog2_min1(max_layers);
  endfunction

  function automatic int width_nlay(input int max_layers);
    return clog2_min1(max_layers + 1);
  endfunction

  function automatic int width_iter(input int max_iter);
    return clog2_min1(max_iter + 1);
  endfunction

  localparam int DEF_WIDTH_BLOCK = width_block(DEF_MAX_BLOCK_SIZE);
  localparam logic [DEF_WIDTH_BLOCK-1:0] NULL_SHIFT = '1;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    FETCH    = 6'b000010,
    ISSUE    = 6'b000100,
    WAIT_ROW = 6'b001000,
    CHECK    = 6'b010000,
    DONE     = 6'b100000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ldpc_layer_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ldpc_layer_sched : per-iteration layer sweep sequencer for the route stage.
//                    LDPC_EARLY_TERM_EN enables exit on first good syndrome.
//                    Rev 1.0
// ----------------------------------------------------------------------------
module ldpc_layer_sched
  import ldpc_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = DEF_MAX_BLOCK_SIZE,
  parameter int MAX_LAYERS     = DEF_MAX_LAYERS,
  parameter int MAX_ITER       = DEF_MAX_ITER,
  localparam int WIDTH_BLOCK   = width_block(MAX_BLOCK_SIZE),
  localparam int WIDTH_LAYER   = width_layer(MAX_LAYERS),
  localparam int WIDTH_NLAY    = width_nlay(MAX_LAYERS),
  localparam int WIDTH_ITER    = width_iter(MAX_ITER)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH_NLAY-1:0]  num_layers_in,
  input  logic [WIDTH_ITER-1:0]  max_iter_in,
  output logic [WIDTH_LAYER-1:0] shift_addr,
  input  logic [WIDTH_BLOCK-1:0] shift_data,
  output logic                   start_row,
  output logic [WIDTH_BLOCK-1:0] cell_out,
  input  logic                   row_done,
  input  logic                   syndrome_ok,
  output logic                   busy,
  output logic                   done,
  output logic                   success,
  output logic [WIDTH_ITER-1:0]  iter_count
);

  state_t                 state;
  logic [WIDTH_LAYER-1:0] layer;
  logic [WIDTH_NLAY-1:0]  num_layers;
  logic [WIDTH_ITER-1:0]  max_iter;

  logic [WIDTH_ITER:0]    iter_next;
  logic [WIDTH_NLAY-1:0]  layer_next;
  logic                   last_iter;
  logic                   last_layer;
  logic                   exit_now;

  // The ROM address tracks the layer register directly, so it is stable
  // throughout FETCH and the ROM word arrives during ISSUE.
  assign shift_addr = layer;

  always_comb begin
    iter_next  = {1'b0, iter_count} + {{WIDTH_ITER{1'b0}}, 1'b1};
    layer_next = WIDTH_NLAY'(layer) + WIDTH_NLAY'(1);
    last_iter  = (iter_next >= {1'b0, max_iter});
    last_layer = (layer_next >= num_layers) ||
                 (layer == WIDTH_LAYER'(MAX_LAYERS - 1));
`ifdef LDPC_EARLY_TERM_EN
    exit_now   = last_iter || syndrome_ok;
`else
    exit_now   = last_iter;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      layer      <= '0;
      num_layers <= '0;
      max_iter   <= '0;
      start_row  <= 1'b0;
      cell_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      success    <= 1'b0;
      iter_count <= '0;
    end else begin
      start_row <= 1'b0;
      done      <= 1'b0;
      // Abort pre-empts a coincident row_done; DONE itself cannot be aborted.
      if (abort && (state != IDLE) && (state != DONE)) begin
        state   <= DONE;
        done    <= 1'b1;
        success <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              num_layers <= num_layers_in;
              max_iter   <= max_iter_in;
              iter_count <= '0;
              success    <= 1'b0;
              layer      <= '0;
              busy       <= 1'b1;
              if ((num_layers_in == '0) || (max_iter_in == '0)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
          FETCH: state <= ISSUE;
          ISSUE: begin
            cell_out  <= shift_data;
            start_row <= 1'b1;
            state     <= WAIT_ROW;
          end
          WAIT_ROW: begin
            if (row_done) begin
              if (last_layer) begin
                state <= CHECK;
              end else begin
                layer <= layer + WIDTH_LAYER'(1);
                state <= FETCH;
              end
            end
          end
          CHECK: begin
            iter_count <= iter_next[WIDTH_ITER-1:0];
            if (exit_now) begin
              state   <= DONE;
              done    <= 1'b1;
              success <= syndrome_ok;
            end else begin
              layer <= '0;
              state <= FETCH;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_layer_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ldpc_layer_sched : vector table plus randomized decodes against a
//                      sweep-level reference model, with corner sequences.
//                      Rev 1.0
// ----------------------------------------------------------------------------
module tb_ldpc_layer_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] num_layers_in;
  logic [3:0] max_iter_in;
  logic [1:0] shift_addr;
  logic [2:0] shift_data;
  logic       start_row;
  logic [2:0] cell_out;
  wire        row_done;
  wire        syndrome_ok;
  logic       busy;
  logic       done;
  logic       success;
  logic [3:0] iter_count;

  ldpc_layer_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_layers_in(num_layers_in),
    .max_iter_in  (max_iter_in),
    .shift_addr   (shift_addr),
    .shift_data   (shift_data),
    .start_row    (start_row),
    .cell_out     (cell_out),
    .row_done     (row_done),
    .syndrome_ok  (syndrome_ok),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .iter_count   (iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Environment models: shift ROM, route stage, syndrome source
  logic [2:0] rom_mem [4];
  int         lat = 4;
  int         rcnt = 0;
  logic       route_rd = 1'b0;
  logic       spur_rd = 1'b0;
  int         cur_nl = 0;
  int         cur_oki = 0;
  int         pulse_base = 0;
  int         pulse_cnt = 0;
  int         done_cnt = 0;
  logic [2:0] cells [$];

  assign row_done    = route_rd | spur_rd;
  // Syndrome becomes good once cur_oki full sweeps have been issued.
  assign syndrome_ok = (cur_oki != 0) && ((pulse_cnt - pulse_base) >= cur_oki * cur_nl);

  initial begin
    shift_data = '0;
    forever begin
      @(posedge clk);
      shift_data <= rom_mem[shift_addr];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      route_rd = 1'b0;
      if (start_row) rcnt = lat;
      else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) route_rd = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (start_row) begin
      cells.push_back(cell_out);
      pulse_cnt++;
    end
    if (done) done_cnt++;
  end

  // Reference model: iterations run and final result of one decode.
  function automatic int ref_iters(input int nl, input int mi, input int oki);
    if (nl == 0 || mi == 0) return 0;
`ifdef LDPC_EARLY_TERM_EN
    if (oki != 0 && oki < mi) return oki;
`endif
    return mi;
  endfunction

  function automatic bit ref_success(input int nl, input int mi, input int oki);
    int it;
    it = ref_iters(nl, mi, oki);
    return (it > 0) && (oki != 0) && (oki <= it);
  endfunction

  typedef struct {
    int               nl;
    int               mi;
    int               oki;
    int               lt;
    bit               poke;
    logic [3:0][2:0]  rom;
    int               exp_iters;
    bit               exp_success;
  } vec_t;

  function automatic vec_t mk(input int nl, input int mi, input int oki, input int lt,
                              input bit poke, input logic [3:0][2:0] rom);
    vec_t v;
    v.nl = nl; v.mi = mi; v.oki = oki; v.lt = lt; v.poke = poke; v.rom = rom;
    v.exp_iters   = ref_iters(nl, mi, oki);
    v.exp_success = ref_success(nl, mi, oki);
    return v;
  endfunction

  function automatic logic [3:0][2:0] rom4(input int a, input int b, input int c, input int d);
    logic [3:0][2:0] r;
    r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d);
    return r;
  endfunction

  task automatic load_env(input vec_t v);
    for (int i = 0; i < 4; i++) rom_mem[i] = v.rom[i];
    cur_nl = v.nl; cur_oki = v.oki; lat = v.lt; pulse_base = pulse_cnt;
  endtask

  task automatic kick(input int nl, input int mi);
    @(posedge clk); #1;
    start = 1'b1; num_layers_in = 3'(nl); max_iter_in = 4'(mi);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_decode(input vec_t v, input string tag);
    int pb, db, cb, cyc, mism, n, got_it, got_s;
    load_env(v);
    pb = pulse_cnt; db = done_cnt; cb = cells.size();
    kick(v.nl, v.mi);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
      if (v.poke && route_rd && !done) begin
        // DUT enters FETCH next cycle: fire a stray row_done and a stray start there
        @(posedge clk); #1;
        spur_rd = 1'b1; start = 1'b1; num_layers_in = 3'd1; max_iter_in = 4'd1;
        @(posedge clk); #1;
        spur_rd = 1'b0; start = 1'b0;
        cyc += 2;
      end
    end while (!done && cyc < 3000);
    check({tag, "_done_seen"}, int'(done), 1);
    got_it = int'(iter_count);
    got_s  = int'(success);
    repeat (3) @(negedge clk);
    #1;
    n = pulse_cnt - pb;
    mism = 0;
    for (int k = 0; k < n && k < v.exp_iters * v.nl; k++)
      if (cells[cb + k] != v.rom[k % v.nl]) mism++;
    check({tag, "_start_row_count"}, n, v.exp_iters * v.nl);
    check({tag, "_cell_seq_errors"}, mism, 0);
    check({tag, "_iter_count"}, got_it, v.exp_iters);
    check({tag, "_success"}, got_s, int'(v.exp_success));
    check({tag, "_done_pulses"}, done_cnt - db, 1);
    check({tag, "_busy_after"}, int'(busy), 0);
    if (v.exp_iters == 0) check({tag, "_degenerate_done_within_2"}, int'(cyc <= 2), 1);
  endtask

  task automatic wait_pulses(input int pb, input int target, input bit need_rd);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!((pulse_cnt - pb) >= target && (!need_rd || route_rd)) && cyc < 2000);
    check("wait_pulses_reached", int'(cyc < 2000), 1);
  endtask

  vec_t vecs [$];

  initial begin
    vec_t v;
    int pb, db;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_layers_in = '0; max_iter_in = '0;
    for (int i = 0; i < 4; i++) rom_mem[i] = '0;

    vecs.push_back(mk(3, 2, 0, 4, 1'b0, rom4(2, 7, 5, 0)));   // basic sweep incl. null cell
    vecs.push_back(mk(3, 10, 3, 2, 1'b0, rom4(1, 4, 6, 3)));  // syndrome good from iteration 3
    vecs.push_back(mk(0, 3, 0, 2, 1'b0, rom4(1, 2, 3, 4)));   // zero layers
    vecs.push_back(mk(2, 0, 1, 2, 1'b0, rom4(1, 2, 3, 4)));   // zero iterations
    vecs.push_back(mk(2, 3, 0, 3, 1'b1, rom4(6, 3, 1, 1)));   // stray start/row_done
    vecs.push_back(mk(4, 15, 0, 1, 1'b0, rom4(7, 0, 3, 5)));  // all limits at max
    vecs.push_back(mk(1, 1, 1, 1, 1'b0, rom4(5, 0, 0, 0)));   // single cell, single pass
    for (int i = 0; i < 8; i++) begin
      int mi;
      mi = $urandom_range(0, 6);
      vecs.push_back(mk($urandom_range(0, 4), mi, $urandom_range(0, mi + 1),
                        $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                        rom4($urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 7))));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_start_row", int'(start_row), 0);
    check("rst_iter_count", int'(iter_count), 0);
    check("rst_shift_addr", int'(shift_addr), 0);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      run_decode(vecs[i], $sformatf("v%0d", i));
      repeat (8) @(posedge clk);
    end

    // Abort in WAIT_ROW of iteration 2, layer 1
    v = mk(3, 3, 0, 6, 1'b0, rom4(1, 2, 3, 0));
    load_env(v);
    pb = pulse_cnt; db = done_cnt;
    kick(3, 3);
    wait_pulses(pb, 5, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done", int'(done), 1);
    check("abort_success", int'(success), 0);
    check("abort_iter_count", int'(iter_count), 1);
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_more_rows", pulse_cnt - pb, 5);
    check("abort_done_pulses", done_cnt - db, 1);
    check("abort_busy_after", int'(busy), 0);

    // Abort coincident with the final row_done while syndrome is good
    v = mk(2, 1, 1, 3, 1'b0, rom4(4, 5, 0, 0));
    load_env(v);
    pb = pulse_cnt;
    kick(2, 1);
    wait_pulses(pb, 2, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_vs_rowdone_done", int'(done), 1);
    check("abort_vs_rowdone_success", int'(success), 0);
    check("abort_vs_rowdone_iter", int'(iter_count), 0);
    repeat (10) @(posedge clk);

    // Synchronous reset while waiting on a row in iteration 2
    v = mk(3, 2, 0, 5, 1'b0, rom4(6, 3, 2, 0));
    load_env(v);
    pb = pulse_cnt;
    kick(3, 2);
    wait_pulses(pb, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_start_row", int'(start_row), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_success", int'(success), 0);
    check("midrst_iter_count", int'(iter_count), 0);
    check("midrst_cell_out", int'(cell_out), 0);
    check("midrst_shift_addr", int'(shift_addr), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("midrst_no_more_rows", pulse_cnt - pb, 5);
    run_decode(mk(3, 2, 2, 2, 1'b0, rom4(6, 3, 2, 0)), "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
